// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch (IF) and
// data (DM) ports, with DM priority bounded by a starvation limit and a final dump on halt.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  input  logic        halt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_createdump,
  output logic        busy
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HALTED} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_dm;
  logic          lat_wr;
  logic          grant_dm;
  logic          grant_if;

  // DM normally wins; IF is forced through once DM has won STARVE_MAX times in its face.
  always_comb begin
    grant_dm = dm_req && !(starve_cnt == SW'(STARVE_MAX) && if_req);
    grant_if = if_req && !grant_dm;
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign busy     = (state != IDLE) && (state != HALTED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      starve_cnt     <= '0;
      owner_dm       <= 1'b0;
      lat_wr         <= 1'b0;
      mem_en         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_createdump <= 1'b0;
      if_done        <= 1'b0;
      dm_done        <= 1'b0;
      if_rdata       <= '0;
      dm_rdata       <= '0;
    end else begin
      mem_en         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_createdump <= 1'b0;
      if_done        <= 1'b0;
      dm_done        <= 1'b0;
      case (state)
        // RESP shares the grant logic with IDLE so accesses can run back-to-back.
        IDLE, RESP: begin
          if (halt) begin
            state          <= HALTED;
            mem_createdump <= 1'b1;
          end else if (grant_dm || grant_if) begin
            state     <= ISSUE;
            owner_dm  <= grant_dm;
            lat_wr    <= grant_dm & dm_wr;
            mem_en    <= 1'b1;
            mem_wr    <= grant_dm & dm_wr;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_wdata <= grant_dm ? dm_wdata : '0;
            if (grant_if)
              starve_cnt <= '0;
            else if (if_req && starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + SW'(1);
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(MEM_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RESP;
            if (owner_dm) begin
              dm_done  <= 1'b1;
              dm_rdata <= lat_wr ? 16'h0000 : mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a transaction-level model predicts every output each cycle,
// directed scenarios pin the model with literal values, then randomized traffic follows.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        if_stall;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_done;
  logic [15:0] dm_rdata;
  logic        dm_stall;
  logic        halt = 1'b0;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_createdump;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .halt(halt), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_createdump(mem_createdump), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] initVal(input int i);
    return 16'((i * 16'h0137) ^ 16'h5A3C);
  endfunction

  // Memory: writes land on the enable edge, read data appears MEM_LAT cycles after enable.
  logic [15:0] ram [0:255];
  logic        ram_init = 1'b0;
  bit          pv [0:MEM_LAT-1];
  logic [15:0] pd [0:MEM_LAT-1];
  logic [15:0] junk = '0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= initVal(i);
      ram_init <= 1'b1;
    end else if (mem_en && mem_wr) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    pv[0] <= mem_en && !mem_wr;
    pd[0] <= ram[mem_addr[7:0]];
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    junk <= 16'($urandom);
  end

  assign mem_rdata = pv[MEM_LAT-1] ? pd[MEM_LAT-1] : junk;

  // Transaction-level model: each grant is one record with a fixed issue/done/free timeline.
  bit          model_ready = 1'b0;
  logic [15:0] mdl_mem [0:255];
  int          e = 0;
  int          decide_at = 0;
  int          g_edge = 0;
  bit          act = 1'b0;
  bit          halted = 1'b0;
  int          starve = 0;
  bit          a_dm = 1'b0;
  logic [15:0] a_data = '0;
  bit          x_mem_en, x_mem_wr, x_if_done, x_dm_done, x_dump, x_busy;
  logic [15:0] x_mem_addr, x_mem_wdata, x_if_rdata, x_dm_rdata;

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = initVal(i);
    forever begin
      @(posedge clk);
      e++;
      x_mem_en = 0; x_mem_wr = 0; x_if_done = 0; x_dm_done = 0; x_dump = 0;
      if (!rst) begin
        model_ready = 1; act = 0; halted = 0; starve = 0; decide_at = e + 1;
        x_if_rdata = '0; x_dm_rdata = '0; x_busy = 0;
      end else if (!halted) begin
        if (act && e == g_edge + MEM_LAT + 1) begin
          if (a_dm) begin x_dm_done = 1; x_dm_rdata = a_data; end
          else begin x_if_done = 1; x_if_rdata = a_data; end
        end
        if (e == decide_at) begin
          act = 0;
          decide_at = e + 1;
          if (halt) begin
            halted = 1; x_dump = 1;
          end else if (dm_req || if_req) begin
            a_dm = dm_req && !(starve == STARVE_MAX && if_req);
            if (a_dm) starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : starve;
            else starve = 0;
            act = 1; g_edge = e; decide_at = e + MEM_LAT + 2;
            x_mem_en = 1;
            x_mem_wr = a_dm && dm_wr;
            x_mem_addr = a_dm ? dm_addr : if_addr;
            x_mem_wdata = dm_wdata;
            if (x_mem_wr) begin
              mdl_mem[x_mem_addr[7:0]] = dm_wdata;
              a_data = '0;
            end else begin
              a_data = mdl_mem[x_mem_addr[7:0]];
            end
          end
        end
        x_busy = act && (e <= g_edge + MEM_LAT + 1);
      end else begin
        x_busy = 0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic checkOutput();
    if (!model_ready) return;
    cmp("mem_en", 16'(mem_en), 16'(x_mem_en));
    cmp("mem_wr", 16'(mem_wr), 16'(x_mem_wr));
    if (x_mem_en) cmp("mem_addr", mem_addr, x_mem_addr);
    if (x_mem_en && x_mem_wr) cmp("mem_wdata", mem_wdata, x_mem_wdata);
    cmp("if_done", 16'(if_done), 16'(x_if_done));
    cmp("dm_done", 16'(dm_done), 16'(x_dm_done));
    cmp("if_rdata", if_rdata, x_if_rdata);
    cmp("dm_rdata", dm_rdata, x_dm_rdata);
    cmp("createdump", 16'(mem_createdump), 16'(x_dump));
    cmp("busy", 16'(busy), 16'(x_busy));
    cmp("if_stall", 16'(if_stall), 16'(if_req & ~x_if_done));
    cmp("dm_stall", 16'(dm_stall), 16'(dm_req & ~x_dm_done));
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput();
    end
  endtask

  int       cnt;
  bit [4:0] seq;
  int       ndone;
  int       halt_age;

  initial begin
    // reset
    applyStimulus(3);
    rst = 1'b1;
    applyStimulus(2);
    cmp("reset_busy", 16'(busy), 16'h0000);

    // DM write 0x0018 <- 0x1234, then fetch it back
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0018; dm_wdata = 16'h1234;
    applyStimulus(6);
    cmp("lit_wr18_done", 16'(dm_done), 16'h0001);
    dm_req = 0; dm_wr = 0;
    applyStimulus(1);
    if_req = 1; if_addr = 16'h0018;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1);
      if (k == 1) begin
        cmp("lit_fetch_en", 16'(mem_en), 16'h0001);
        cmp("lit_fetch_addr", mem_addr, 16'h0018);
      end
      if (k == 5) cmp("lit_fetch_stall", 16'(if_stall), 16'h0001);
    end
    cmp("lit_fetch_done", 16'(if_done), 16'h0001);
    cmp("lit_fetch_data", if_rdata, 16'h1234);
    if_req = 0;
    applyStimulus(1);

    // write then back-to-back read
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0040; dm_wdata = 16'hBEEF;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1);
      if (k == 1) cmp("lit_wr_strobe", 16'(mem_wr), 16'h0001);
      if (k == 6) begin
        cmp("lit_wr_done", 16'(dm_done), 16'h0001);
        cmp("lit_wr_rdata", dm_rdata, 16'h0000);
        dm_wr = 0; dm_wdata = 16'h0000;
      end
      if (k == 7) cmp("lit_rd_issue", 16'(mem_en), 16'h0001);
    end
    cmp("lit_rd_done", 16'(dm_done), 16'h0001);
    cmp("lit_rd_data", dm_rdata, 16'hBEEF);
    dm_req = 0;
    applyStimulus(1);

    // starvation: both ports keep requesting
    if_req = 1; if_addr = 16'h0020; dm_req = 1; dm_addr = 16'h0041;
    seq = '0; ndone = 0;
    for (int k = 0; k < 60 && ndone < 5; k++) begin
      applyStimulus(1);
      if (if_done || dm_done) begin
        seq = {seq[3:0], dm_done};
        ndone++;
      end
    end
    cmp("lit_starve_count", 16'(ndone), 16'd5);
    cmp("lit_starve_order", 16'(seq), 16'(5'b11101));
    if_req = 0; dm_req = 0;
    applyStimulus(8);

    // halt during a fetch
    if_req = 1; if_addr = 16'h0003;
    applyStimulus(3);
    halt = 1;
    applyStimulus(3);
    cmp("lit_halt_done", 16'(if_done), 16'h0001);
    if_req = 0;
    applyStimulus(1);
    cmp("lit_dump", 16'(mem_createdump), 16'h0001);
    if_req = 1; dm_req = 1;
    applyStimulus(10);

    // reset, then reset in the middle of an access
    rst = 0; halt = 0; if_req = 0; dm_req = 0;
    applyStimulus(1);
    rst = 1;
    applyStimulus(1);
    if_req = 1; if_addr = 16'h0018;
    applyStimulus(3);
    rst = 0;
    applyStimulus(1);
    cmp("lit_rst_done", 16'(if_done), 16'h0000);
    rst = 1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      cnt++;
      if (if_done) break;
    end
    cmp("lit_rst_latency", 16'(cnt), 16'd6);
    if_req = 0;

    // idle
    applyStimulus(20);
    cmp("lit_idle_busy", 16'(busy), 16'h0000);

    // randomized traffic with occasional halts and resets
    halt_age = 0;
    for (int c = 0; c < 2500; c++) begin
      applyStimulus(1);
      rst = ($urandom_range(0, 249) != 0);
      if (halt) halt_age++;
      else if ($urandom_range(0, 299) == 0) halt = 1;
      if (halt_age > 25) begin
        rst = 0; halt = 0; halt_age = 0;
      end
      if (if_req && if_done) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom);
      end else if (!if_req) begin
        if_req = ($urandom_range(0, 2) == 0); if_addr = 16'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        if_addr = 16'($urandom);
      end
      if (dm_req && dm_done) begin
        dm_req = 1'($urandom_range(0, 1)); dm_addr = 16'($urandom);
        dm_wr = 1'($urandom_range(0, 1)); dm_wdata = 16'($urandom);
      end else if (!dm_req) begin
        dm_req = ($urandom_range(0, 2) == 0); dm_addr = 16'($urandom);
        dm_wr = 1'($urandom_range(0, 1)); dm_wdata = 16'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        dm_addr = 16'($urandom); dm_wr = 1'($urandom_range(0, 1)); dm_wdata = 16'($urandom);
      end
    end
    applyStimulus(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
